// File: rtl/char_pkg.sv
// Shared constants for the character path: page geometry, clear code,
// scheduler state encodings and a saturating counter helper.
package char_pkg;

  localparam int unsigned COLS       = 20;
  localparam int unsigned ROWS       = 7;
  localparam int unsigned PAGE_CHARS = COLS * ROWS;
  localparam logic [7:0]  CLEAR_CODE = 8'hFF;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] limit);
    return (cnt >= limit) ? limit : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO with first-word-fall-through head; DEPTH must be a power of 2.
module char_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full_c;
  assign w_do_pop  = i_pop & ~o_empty_c;

  // Storage needs no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/char_input_scheduler.sv
// Round-robin merge of two byte sources into a paced feeder write stream,
// with page tracking and optional clear injection when the page fills.
module char_input_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned PAGE_CHARS = char_pkg::PAGE_CHARS,
  parameter logic [7:0]  CLEAR_CODE = char_pkg::CLEAR_CODE,
  parameter bit          AUTO_CLEAR = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] feed_data,
  output logic       feed_we,
  output logic [7:0] char_count,
  output logic       page_full,
  output logic       busy
);
  import char_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
  localparam logic [7:0]  PAGE_LIMIT = 8'(PAGE_CHARS);

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic [GW-1:0]      r_gap_cnt, w_gap_nxt;
  logic               r_last_grant, w_last_grant_nxt;
  logic               r_feed_we, w_feed_we_nxt;
  logic [7:0]         r_feed_data, w_feed_data_nxt;
  logic [7:0]         r_char_count, w_cnt_nxt;
  logic               r_page_full;
  logic               r_busy;

  logic               w_a_ready, w_b_ready;
  logic               w_push, w_pop;
  logic [7:0]         w_push_data;
  logic [7:0]         w_head;
  logic               w_full, w_empty;
  logic [CW-1:0]      w_fifo_cnt, w_fifo_cnt_nxt;

  char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_fifo_cnt)
  );

  // Arbiter: favour the source not granted on the last transfer.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (!w_full) begin
      if (a_valid && b_valid) begin
        if (r_last_grant == SRC_B) w_a_ready = 1'b1;
        else                       w_b_ready = 1'b1;
      end else begin
        w_a_ready = a_valid;
        w_b_ready = b_valid;
      end
    end
  end

  assign w_push      = (a_valid & w_a_ready) | (b_valid & w_b_ready);
  assign w_push_data = w_a_ready ? a_data : b_data;

  always_comb begin
    w_last_grant_nxt = r_last_grant;
    if (a_valid && w_a_ready)      w_last_grant_nxt = SRC_A;
    else if (b_valid && w_b_ready) w_last_grant_nxt = SRC_B;
  end

  // Next-state and registered-output values; the strobe registers on entry to ISSUE/CLEAR.
  always_comb begin
    w_state_nxt     = r_state;
    w_gap_nxt       = r_gap_cnt;
    w_feed_we_nxt   = 1'b0;
    w_feed_data_nxt = r_feed_data;
    w_cnt_nxt       = r_char_count;
    w_pop           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_feed_we_nxt = 1'b1;
          if (AUTO_CLEAR && r_page_full) begin
            w_state_nxt     = ST_CLEAR;
            w_feed_data_nxt = CLEAR_CODE;
            w_cnt_nxt       = 8'd0;
          end else begin
            w_state_nxt     = ST_ISSUE;
            w_feed_data_nxt = w_head;
            w_cnt_nxt       = (w_head == CLEAR_CODE) ? 8'd0 : sat_inc(r_char_count, PAGE_LIMIT);
          end
        end
      end
      ST_ISSUE, ST_CLEAR: begin
        w_pop       = (r_state == ST_ISSUE);
        w_gap_nxt   = '0;
        w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (r_gap_cnt + GW'(1) >= GW'(GAP_CYCLES)) w_state_nxt = ST_IDLE;
        else                                      w_gap_nxt   = r_gap_cnt + GW'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_fifo_cnt_nxt = w_fifo_cnt + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_last_grant <= SRC_B;
      r_feed_we    <= 1'b0;
      r_feed_data  <= 8'd0;
      r_char_count <= 8'd0;
      r_page_full  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_feed_we    <= w_feed_we_nxt;
      r_feed_data  <= w_feed_data_nxt;
      r_char_count <= w_cnt_nxt;
      r_page_full  <= (w_cnt_nxt == PAGE_LIMIT);
      r_busy       <= (w_fifo_cnt_nxt != '0) || (w_state_nxt != ST_IDLE);
    end
  end

  assign a_ready    = w_a_ready;
  assign b_ready    = w_b_ready;
  assign feed_we    = r_feed_we;
  assign feed_data  = r_feed_data;
  assign char_count = r_char_count;
  assign page_full  = r_page_full;
  assign busy       = r_busy;

endmodule

// File: tb/tb_char_input_scheduler.sv
// Scoreboard bench for char_input_scheduler with default parameters
// (depth 4, gap 2, 140-char page, auto clear on).
module tb_char_input_scheduler;

  localparam int GAP  = 2;
  localparam int PAGE = 140;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [7:0] feed_data;
  logic       feed_we;
  logic [7:0] char_count;
  logic       page_full;
  logic       busy;

  char_input_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .feed_data  (feed_data),
    .feed_we    (feed_we),
    .char_count (char_count),
    .page_full  (page_full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] c;
    logic       pf;
  } exp_t;

  exp_t sb[$];
  int   strobe_cyc[$];
  logic grants[$];
  int   model_cnt = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected strobes in FIFO order, including an injected clear once the page is full.
  task automatic sb_push(input logic [7:0] d);
    exp_t e;
    if (d == 8'hFF) begin
      model_cnt = 0;
      e.d = 8'hFF; e.c = 8'd0; e.pf = 1'b0;
      sb.push_back(e);
    end else begin
      if (model_cnt == PAGE) begin
        model_cnt = 0;
        e.d = 8'hFF; e.c = 8'd0; e.pf = 1'b0;
        sb.push_back(e);
      end
      model_cnt++;
      e.d = d; e.c = 8'(model_cnt); e.pf = (model_cnt == PAGE);
      sb.push_back(e);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && feed_we === 1'b1) begin
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(feed_data), 32'h1FF);
      end else begin
        mon_e = sb.pop_front();
        check("feed_data", 32'(feed_data), 32'(mon_e.d));
        check("char_count", 32'(char_count), 32'(mon_e.c));
        check("page_full", 32'(page_full), 32'(mon_e.pf));
      end
    end
  end

  task automatic drive_src(input logic src, input int n, input logic [7:0] base,
                           input bit incr, output int first_stall);
    logic [7:0] d;
    logic       rdy;
    bit         acc;
    int         tries;
    first_stall = -1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      d = incr ? 8'(base + 8'(i)) : base;
      if (src) begin b_valid = 1'b1; b_data = d; end
      else     begin a_valid = 1'b1; a_data = d; end
      acc = 1'b0;
      tries = 0;
      rdy = 1'b0;
      while (!acc && tries < 200) begin
        #1;
        rdy = src ? b_ready : a_ready;
        if (rdy) begin
          acc = 1'b1;
          sb_push(d);
          grants.push_back(src);
        end else if (first_stall < 0) begin
          first_stall = i;
        end
        @(negedge clk);
        tries++;
      end
      if (!acc) check("accept_timeout", 32'(rdy), 32'd1);
    end
    if (src) b_valid = 1'b0;
    else     a_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    check("rst_feed_we", 32'(feed_we), 32'd0);
    check("rst_feed_data", 32'(feed_data), 32'd0);
    check("rst_char_count", 32'(char_count), 32'd0);
    check("rst_page_full", 32'(page_full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int fs, fs2;
    reset_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data  = 8'd0; b_data  = 8'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single byte from A
    strobe_cyc.delete();
    drive_src(1'b0, 1, 8'h41, 1'b0, fs);
    wait_idle();
    check("single_strobes", 32'(strobe_cyc.size()), 32'd1);
    check("single_count", 32'(char_count), 32'd1);

    // Both sources valid: A wins the first tie after reset, then alternation
    do_reset();
    strobe_cyc.delete();
    grants.delete();
    fork
      drive_src(1'b0, 2, 8'h31, 1'b0, fs);
      drive_src(1'b1, 2, 8'h32, 1'b0, fs2);
    join
    wait_idle();
    check("rr_grants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++) check("rr_grant_order", 32'(grants[i]), 32'(i % 2));
    check("rr_strobes", 32'(strobe_cyc.size()), 32'd4);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check("strobe_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'(GAP + 2));

    // Backpressure: 5 accepted back-to-back, sixth stalls on a full FIFO
    strobe_cyc.delete();
    drive_src(1'b0, 8, 8'hA0, 1'b1, fs);
    check("first_stall_idx", 32'(fs), 32'd5);
    wait_idle();
    check("bp_strobes", 32'(strobe_cyc.size()), 32'd8);

    // Source clear after 10 characters
    drive_src(1'b0, 10, 8'h61, 1'b1, fs);
    drive_src(1'b1, 1, 8'hFF, 1'b0, fs);
    wait_idle();
    check("src_clear_count", 32'(char_count), 32'd0);

    // Page fill: 140 characters, injected clear, 141st character
    strobe_cyc.delete();
    drive_src(1'b0, 141, 8'h20, 1'b1, fs);
    wait_idle();
    check("page_strobes", 32'(strobe_cyc.size()), 32'd142);
    check("page_after_count", 32'(char_count), 32'd1);
    check("page_after_full", 32'(page_full), 32'd0);

    // Reset with 3 bytes buffered and the FSM in its gap
    drive_src(1'b0, 4, 8'h50, 1'b1, fs);
    do_reset();
    repeat (30) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_count", 32'(char_count), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
